mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single line-wide main-memory port between the iCache fill path and the dCache fill/write-back path. Accepts level-held miss requests from both caches, arbitrates round-robin, and sequences a dCache dirty-line eviction (write) before the corresponding fill (read). Drives the memory handshake and returns fill data to the owning cache with a one-cycle ready pulse. All logic is on the rising edge of `clk`; the caches sample its outputs on their negedge.

## Interface
- `ADDR_WIDTH`, 32, memory address width (matches `MEM_ADDRESS_LEN`)
- `LINE_WIDTH`, 128, cache line width in bits (matches `ICACHE_LINE_WIDTH`/`DCACHE_LINE_WIDTH`)
- `OFFSET_BITS`, 4, byte-in-line bits cleared on every memory address
- `clk` in 1 system clock; single clock domain
- `reset` in 1 synchronous, active-high reset
- `ic_req` in 1 iCache miss request, level-held until `ic_fill_rdy`
- `ic_addr` in ADDR_WIDTH iCache miss address
- `ic_fill_data` out LINE_WIDTH line returned to iCache
- `ic_fill_rdy` out 1 one-cycle pulse, `ic_fill_data` valid
- `dc_req` in 1 dCache miss request, level-held until `dc_fill_rdy`
- `dc_addr` in ADDR_WIDTH dCache miss address
- `dc_evict` in 1 victim line is dirty; write-back required before fill
- `dc_evict_addr` in ADDR_WIDTH victim line address
- `dc_evict_data` in LINE_WIDTH victim line data
- `dc_wb_done` out 1 one-cycle pulse, write-back accepted by memory
- `dc_fill_data` out LINE_WIDTH line returned to dCache
- `dc_fill_rdy` out 1 one-cycle pulse, `dc_fill_data` valid
- `mem_req` out 1 memory transaction request
- `mem_we` out 1 1 = write, 0 = read
- `mem_addr` out ADDR_WIDTH line-aligned address
- `mem_wdata` out LINE_WIDTH write data
- `mem_rdata` in LINE_WIDTH read data, valid when `mem_rdy`
- `mem_rdy` in 1 memory completes current transaction this cycle
- `owner` out 2 00 idle, 01 iCache, 10 dCache

## Operation
- States: IDLE, I_RD, D_WB, D_GAP, D_RD, RESP.
- IDLE: only `ic_req` -> I_RD; only `dc_req` -> D_WB if `dc_evict` else D_RD; both -> grant the requester not served last (`last_grant` register, reset value = iCache, so dCache wins the first tie). Neither -> stay.
- At grant: latch miss address, and for dCache `dc_evict_addr`/`dc_evict_data`; later input changes are ignored until RESP. `last_grant` updated at grant.
- Address rule: `mem_addr` = latched address with bits [OFFSET_BITS-1:0] forced to 0; no other arithmetic.
- I_RD / D_RD: `mem_req`=1, `mem_we`=0. On `mem_rdy`: capture `mem_rdata` into the owner's fill_data register, -> RESP.
- D_WB: `mem_req`=1, `mem_we`=1, `mem_wdata`=latched victim. On `mem_rdy`: `dc_wb_done` pulses next cycle, -> D_GAP.
- D_GAP: `mem_req`=0 for exactly one cycle, -> D_RD (memory sees a deasserted request between write and read).
- RESP: owner's fill_rdy = 1 for this cycle only, `mem_req`=0, -> IDLE. Requester must drop its req by the next rising edge; a req still high in IDLE is treated as a new miss.
- `owner` = 01 in I_RD/RESP(I), 10 in D_WB/D_GAP/D_RD/RESP(D), 00 in IDLE.
- `mem_rdy` outside I_RD/D_WB/D_RD is ignored.
- `reset` (any state): -> IDLE, `last_grant` = iCache, all outputs 0 (incl. `mem_addr`, `mem_wdata`, fill_data registers); any in-flight memory transaction is abandoned (memory shares the same reset).

## Timing
- All outputs registered; every output is 0 after reset.
- Request seen high at edge k in IDLE -> `mem_req`, `mem_addr`, `mem_we`, `mem_wdata` valid from cycle k+1, stable until the edge where `mem_rdy`=1 is sampled.
- Read with memory latency L cycles (`mem_rdy` in L-th cycle of `mem_req`): fill_rdy high in cycle k+L+1; arbiter back in IDLE at k+L+2.
- Dirty miss: write (Lw) + 1 gap + read (Lr); `dc_wb_done` coincident with D_GAP cycle; `dc_fill_rdy` at k+Lw+Lr+2.
- `mem_rdy` in the first cycle of `mem_req` (L=1) is legal.
- Pending requester never waits more than one full transaction of the other (round-robin).

## Test plan
- Clean iCache miss: `ic_req`=1, `ic_addr`=0x0000_1238, mem_rdy after 3 cycles with rdata=0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD -> `mem_addr`=0x0000_1230, `mem_we`=0, `ic_fill_rdy` one cycle with that data, `owner` back to 00.
- Dirty dCache miss: `dc_evict`=1, evict_addr 0x40, data 0x1111…; dc_addr 0x80 -> write to 0x40 with 0x1111…, `dc_wb_done` pulse, one cycle `mem_req`=0, read 0x80, `dc_fill_rdy` pulse.
- Simultaneous `ic_req`/`dc_req` after reset -> dCache served first, then iCache; repeat tie -> iCache first (alternation).
- `ic_addr` changed mid-read from 0x100 to 0x200 -> `mem_addr` stays 0x100 until RESP.
- `reset` asserted in D_RD with `mem_req`=1 -> next cycle all outputs 0, state IDLE; no fill_rdy ever pulses for the aborted request.
- Spurious `mem_rdy`=1 in IDLE -> no fill_rdy, no state change.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles every signal the arbiter exchanges with the iCache, the dCache and
//   the shared main-memory port.
//   slave  : arbiter view (takes cache misses and memory responses, drives
//            fills, write-back status and the memory request)
//   master : environment view (caches plus memory)
//   Ports:
//     ic_req/ic_addr              iCache miss request and address
//     ic_fill_data/ic_fill_rdy    line returned to the iCache, one-cycle valid
//     dc_req/dc_addr              dCache miss request and address
//     dc_evict/_addr/_data        dirty victim to write back before the fill
//     dc_wb_done                  one-cycle pulse, write-back accepted
//     dc_fill_data/dc_fill_rdy    line returned to the dCache, one-cycle valid
//     mem_req/we/addr/wdata       memory transaction request
//     mem_rdata/mem_rdy           memory completion and read data
//     owner                       00 idle, 01 iCache, 10 dCache
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  ic_req;
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic [LINE_WIDTH-1:0] ic_fill_data;
  logic                  ic_fill_rdy;

  logic                  dc_req;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic                  dc_evict;
  logic [ADDR_WIDTH-1:0] dc_evict_addr;
  logic [LINE_WIDTH-1:0] dc_evict_data;
  logic                  dc_wb_done;
  logic [LINE_WIDTH-1:0] dc_fill_data;
  logic                  dc_fill_rdy;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_rdy;

  logic [1:0]            owner;

  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_addr, dc_evict, dc_evict_addr, dc_evict_data,
    input  mem_rdata, mem_rdy,
    output ic_fill_data, ic_fill_rdy,
    output dc_wb_done, dc_fill_data, dc_fill_rdy,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output owner
  );

  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_addr, dc_evict, dc_evict_addr, dc_evict_data,
    output mem_rdata, mem_rdy,
    input  ic_fill_data, ic_fill_rdy,
    input  dc_wb_done, dc_fill_data, dc_fill_rdy,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the line-wide main-memory port between the iCache fill path and
//   the dCache fill/write-back path. Round-robin between the two caches; a
//   dirty dCache miss writes the victim back, idles the memory request for
//   one cycle, then reads the fill line. Every output is a flop.
//   Ports:
//     clk    system clock, all logic on the rising edge
//     reset  synchronous active-high reset
//     bus    mem_arbiter_if.slave (cache requests, fills, memory handshake)
//
//   state | meaning
//   IDLE  | no transaction; arbitrate pending misses
//   I_RD  | reading the iCache fill line
//   D_WB  | writing the dirty dCache victim
//   D_GAP | one cycle with mem_req low between write-back and fill read
//   D_RD  | reading the dCache fill line
//   RESP  | owner's fill_rdy pulse; back to IDLE next cycle
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    I_RD  = 3'd1,
    D_WB  = 3'd2,
    D_GAP = 3'd3,
    D_RD  = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IC   = 2'b01;
  localparam logic [1:0] OWN_DC   = 2'b10;

  // last_grant: 0 = iCache served last, 1 = dCache served last
  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;

  state_t                state, state_n;
  logic                  last_grant, last_grant_n;
  logic [ADDR_WIDTH-1:0] miss_addr, miss_addr_n;
  logic [ADDR_WIDTH-1:0] mem_addr, mem_addr_n;
  logic [LINE_WIDTH-1:0] mem_wdata, mem_wdata_n;
  logic [LINE_WIDTH-1:0] ic_fill_data, ic_fill_data_n;
  logic [LINE_WIDTH-1:0] dc_fill_data, dc_fill_data_n;
  logic                  mem_req, mem_req_n;
  logic                  mem_we, mem_we_n;
  logic                  ic_fill_rdy, ic_fill_rdy_n;
  logic                  dc_fill_rdy, dc_fill_rdy_n;
  logic                  dc_wb_done, dc_wb_done_n;
  logic [1:0]            owner, owner_n;
  logic                  grant_ic, grant_dc;

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= GRANT_IC;
      miss_addr    <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ic_fill_data <= '0;
      dc_fill_data <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      ic_fill_rdy  <= 1'b0;
      dc_fill_rdy  <= 1'b0;
      dc_wb_done   <= 1'b0;
      owner        <= OWN_NONE;
    end else begin
      state        <= state_n;
      last_grant   <= last_grant_n;
      miss_addr    <= miss_addr_n;
      mem_addr     <= mem_addr_n;
      mem_wdata    <= mem_wdata_n;
      ic_fill_data <= ic_fill_data_n;
      dc_fill_data <= dc_fill_data_n;
      mem_req      <= mem_req_n;
      mem_we       <= mem_we_n;
      ic_fill_rdy  <= ic_fill_rdy_n;
      dc_fill_rdy  <= dc_fill_rdy_n;
      dc_wb_done   <= dc_wb_done_n;
      owner        <= owner_n;
    end
  end

  // Next-state logic also produces the next value of every output so the
  // outputs come straight from flops and line up with the state they describe.
  always_comb begin
    state_n        = state;
    last_grant_n   = last_grant;
    miss_addr_n    = miss_addr;
    mem_addr_n     = mem_addr;
    mem_wdata_n    = mem_wdata;
    ic_fill_data_n = ic_fill_data;
    dc_fill_data_n = dc_fill_data;
    mem_req_n      = 1'b0;
    mem_we_n       = 1'b0;
    ic_fill_rdy_n  = 1'b0;
    dc_fill_rdy_n  = 1'b0;
    dc_wb_done_n   = 1'b0;
    owner_n        = owner;

    // On a tie the side that was not served last wins.
    grant_ic = bus.ic_req && (!bus.dc_req || (last_grant == GRANT_DC));
    grant_dc = bus.dc_req && !grant_ic;

    case (state)
      IDLE: begin
        owner_n = OWN_NONE;
        if (grant_ic) begin
          state_n      = I_RD;
          last_grant_n = GRANT_IC;
          owner_n      = OWN_IC;
          mem_addr_n   = line_align(bus.ic_addr);
          mem_req_n    = 1'b1;
        end else if (grant_dc) begin
          last_grant_n = GRANT_DC;
          owner_n      = OWN_DC;
          miss_addr_n  = line_align(bus.dc_addr);
          mem_req_n    = 1'b1;
          if (bus.dc_evict) begin
            state_n     = D_WB;
            mem_we_n    = 1'b1;
            mem_addr_n  = line_align(bus.dc_evict_addr);
            mem_wdata_n = bus.dc_evict_data;
          end else begin
            state_n    = D_RD;
            mem_addr_n = line_align(bus.dc_addr);
          end
        end
      end
      I_RD: begin
        mem_req_n = 1'b1;
        if (bus.mem_rdy) begin
          state_n        = RESP;
          mem_req_n      = 1'b0;
          ic_fill_data_n = bus.mem_rdata;
          ic_fill_rdy_n  = 1'b1;
        end
      end
      D_WB: begin
        mem_req_n = 1'b1;
        mem_we_n  = 1'b1;
        if (bus.mem_rdy) begin
          state_n      = D_GAP;
          mem_req_n    = 1'b0;
          mem_we_n     = 1'b0;
          dc_wb_done_n = 1'b1;
          // Fill address is presented during the gap so it is already stable
          // when mem_req rises again.
          mem_addr_n   = miss_addr;
        end
      end
      D_GAP: begin
        state_n   = D_RD;
        mem_req_n = 1'b1;
      end
      D_RD: begin
        mem_req_n = 1'b1;
        if (bus.mem_rdy) begin
          state_n        = RESP;
          mem_req_n      = 1'b0;
          dc_fill_data_n = bus.mem_rdata;
          dc_fill_rdy_n  = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
        owner_n = OWN_NONE;
      end
      default: begin
        state_n = IDLE;
        owner_n = OWN_NONE;
      end
    endcase
  end

  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.ic_fill_data = ic_fill_data;
  assign bus.ic_fill_rdy  = ic_fill_rdy;
  assign bus.dc_fill_data = dc_fill_data;
  assign bus.dc_fill_rdy  = dc_fill_rdy;
  assign bus.dc_wb_done   = dc_wb_done;
  assign bus.owner        = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .OFFSET_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] RD1 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
  localparam logic [127:0] WB2 = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] RD2 = 128'h22222222_33333333_44444444_55555555;
  localparam logic [127:0] RD3 = 128'h0000000D_C0000001_0000000D_C0000001;
  localparam logic [127:0] RD4 = 128'h1C1C1C1C_00000002_1C1C1C1C_00000002;
  localparam logic [127:0] RD5 = 128'hD2D2D2D2_D2D2D2D2_00000003_00000003;
  localparam logic [127:0] RD6 = 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A;
  localparam logic [127:0] RD7 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.ic_req = 1'b0;  bus.ic_addr = '0;
    bus.dc_req = 1'b0;  bus.dc_addr = '0;
    bus.dc_evict = 1'b0; bus.dc_evict_addr = '0; bus.dc_evict_data = '0;
    bus.mem_rdata = '0; bus.mem_rdy = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_mem_req",   128'(bus.mem_req), 128'd0);
    chk("rst_mem_we",    128'(bus.mem_we), 128'd0);
    chk("rst_mem_addr",  128'(bus.mem_addr), 128'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 128'd0);
    chk("rst_owner",     128'(bus.owner), 128'd0);
    chk("rst_ic_fill",   bus.ic_fill_data, 128'd0);
    chk("rst_dc_fill",   bus.dc_fill_data, 128'd0);
    chk("rst_rdys",      128'({bus.ic_fill_rdy, bus.dc_fill_rdy, bus.dc_wb_done}), 128'd0);

    // clean iCache miss, latency 3
    bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1238;
    tick();
    chk("ic_mem_req",  128'(bus.mem_req), 128'd1);
    chk("ic_mem_addr", 128'(bus.mem_addr), 128'h1230);
    chk("ic_mem_we",   128'(bus.mem_we), 128'd0);
    chk("ic_owner",    128'(bus.owner), 128'd1);
    tick();
    chk("ic_mem_req_c2", 128'(bus.mem_req), 128'd1);
    tick();
    bus.mem_rdy = 1'b1; bus.mem_rdata = RD1;
    tick();
    bus.mem_rdy = 1'b0; bus.ic_req = 1'b0;
    chk("ic_fill_rdy",  128'(bus.ic_fill_rdy), 128'd1);
    chk("ic_fill_data", bus.ic_fill_data, RD1);
    chk("ic_resp_req",  128'(bus.mem_req), 128'd0);
    chk("ic_resp_dc",   128'(bus.dc_fill_rdy), 128'd0);
    tick();
    chk("ic_rdy_pulse", 128'(bus.ic_fill_rdy), 128'd0);
    chk("ic_owner_idle", 128'(bus.owner), 128'd0);

    // dirty dCache miss: write-back latency 1, read latency 2
    bus.dc_req = 1'b1; bus.dc_addr = 32'h80; bus.dc_evict = 1'b1;
    bus.dc_evict_addr = 32'h40; bus.dc_evict_data = WB2;
    tick();
    chk("wb_mem_req",   128'(bus.mem_req), 128'd1);
    chk("wb_mem_we",    128'(bus.mem_we), 128'd1);
    chk("wb_mem_addr",  128'(bus.mem_addr), 128'h40);
    chk("wb_mem_wdata", bus.mem_wdata, WB2);
    chk("wb_owner",     128'(bus.owner), 128'd2);
    bus.mem_rdy = 1'b1;
    tick();
    bus.mem_rdy = 1'b0;
    chk("gap_wb_done", 128'(bus.dc_wb_done), 128'd1);
    chk("gap_mem_req", 128'(bus.mem_req), 128'd0);
    chk("gap_owner",   128'(bus.owner), 128'd2);
    tick();
    chk("drd_mem_req",  128'(bus.mem_req), 128'd1);
    chk("drd_mem_we",   128'(bus.mem_we), 128'd0);
    chk("drd_mem_addr", 128'(bus.mem_addr), 128'h80);
    chk("drd_wb_done",  128'(bus.dc_wb_done), 128'd0);
    tick();
    bus.mem_rdy = 1'b1; bus.mem_rdata = RD2;
    tick();
    bus.mem_rdy = 1'b0; bus.dc_req = 1'b0; bus.dc_evict = 1'b0;
    chk("dc_fill_rdy",  128'(bus.dc_fill_rdy), 128'd1);
    chk("dc_fill_data", bus.dc_fill_data, RD2);
    chk("dc_resp_ic",   128'(bus.ic_fill_rdy), 128'd0);
    tick();
    chk("dc_owner_idle", 128'(bus.owner), 128'd0);

    // tie after reset: dCache first, then repeat tie: iCache first
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ic_req = 1'b1; bus.ic_addr = 32'h300;
    bus.dc_req = 1'b1; bus.dc_addr = 32'h500;
    tick();
    chk("tie1_owner", 128'(bus.owner), 128'd2);
    chk("tie1_addr",  128'(bus.mem_addr), 128'h500);
    bus.mem_rdy = 1'b1; bus.mem_rdata = RD3;
    tick();
    bus.mem_rdy = 1'b0;
    chk("tie1_dc_rdy",  128'(bus.dc_fill_rdy), 128'd1);
    chk("tie1_dc_data", bus.dc_fill_data, RD3);
    chk("tie1_ic_rdy",  128'(bus.ic_fill_rdy), 128'd0);
    bus.dc_addr = 32'h600;
    tick();
    chk("tie_idle_owner", 128'(bus.owner), 128'd0);
    tick();
    chk("tie2_owner", 128'(bus.owner), 128'd1);
    chk("tie2_addr",  128'(bus.mem_addr), 128'h300);
    bus.mem_rdy = 1'b1; bus.mem_rdata = RD4;
    tick();
    bus.mem_rdy = 1'b0; bus.ic_req = 1'b0;
    chk("tie2_ic_data", bus.ic_fill_data, RD4);
    chk("tie2_ic_rdy",  128'(bus.ic_fill_rdy), 128'd1);
    tick();
    tick();
    chk("tie3_owner", 128'(bus.owner), 128'd2);
    chk("tie3_addr",  128'(bus.mem_addr), 128'h600);
    bus.mem_rdy = 1'b1; bus.mem_rdata = RD5;
    tick();
    bus.mem_rdy = 1'b0; bus.dc_req = 1'b0;
    chk("tie3_dc_data", bus.dc_fill_data, RD5);
    tick();

    // iCache address changes mid-read
    bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
    tick();
    chk("hold_addr_c1", 128'(bus.mem_addr), 128'h100);
    bus.ic_addr = 32'h200;
    tick();
    chk("hold_addr_c2", 128'(bus.mem_addr), 128'h100);
    tick();
    chk("hold_addr_c3", 128'(bus.mem_addr), 128'h100);
    bus.mem_rdy = 1'b1; bus.mem_rdata = RD6;
    tick();
    bus.mem_rdy = 1'b0; bus.ic_req = 1'b0;
    chk("hold_fill", bus.ic_fill_data, RD6);
    tick();

    // reset during D_RD with mem_rdy also high: no fill must survive
    bus.dc_req = 1'b1; bus.dc_addr = 32'h700;
    tick();
    chk("abort_mem_req", 128'(bus.mem_req), 128'd1);
    chk("abort_owner",   128'(bus.owner), 128'd2);
    reset = 1'b1; bus.mem_rdy = 1'b1; bus.mem_rdata = RD7;
    tick();
    reset = 1'b0; bus.mem_rdy = 1'b0; bus.dc_req = 1'b0;
    chk("abort_req0",   128'(bus.mem_req), 128'd0);
    chk("abort_owner0", 128'(bus.owner), 128'd0);
    chk("abort_addr0",  128'(bus.mem_addr), 128'd0);
    chk("abort_wdata0", bus.mem_wdata, 128'd0);
    chk("abort_icfd0",  bus.ic_fill_data, 128'd0);
    chk("abort_dcfd0",  bus.dc_fill_data, 128'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_fill", 128'({bus.dc_fill_rdy, bus.ic_fill_rdy}), 128'd0);
      chk("abort_idle",    128'(bus.owner), 128'd0);
    end

    // spurious mem_rdy in IDLE
    bus.mem_rdy = 1'b1; bus.mem_rdata = RD7;
    tick();
    tick();
    chk("spur_rdys",  128'({bus.dc_fill_rdy, bus.ic_fill_rdy, bus.dc_wb_done}), 128'd0);
    chk("spur_req",   128'(bus.mem_req), 128'd0);
    chk("spur_owner", 128'(bus.owner), 128'd0);
    chk("spur_fill",  bus.dc_fill_data, 128'd0);
    bus.mem_rdy = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
